// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package fetch_pkg;

   localparam int unsigned DEF_PC_W    = 8;
   localparam int unsigned DEF_INSTR_W = 16;

   localparam logic [DEF_INSTR_W-1:0] DEF_HALT_OPCODE = 16'hFFFF;
   localparam logic [DEF_INSTR_W-1:0] BUBBLE_INSTR    = '0;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // IF/ID register update: hold, load new word, flush (valid+instr cleared), kill (valid only)
   typedef enum logic [1:0] {
      IFID_HOLD  = 2'd0,
      IFID_LOAD  = 2'd1,
      IFID_FLUSH = 2'd2,
      IFID_KILL  = 2'd3
   } ifid_op_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage signal bundle: hazard/branch inputs, imem read port and IF/ID outputs.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W    = DEF_PC_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W
);

   logic               stall;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               if_id_valid;
   logic [PC_W-1:0]    if_id_pc;
   logic [INSTR_W-1:0] if_id_instr;
   logic               halted;

   modport master (
      input  stall, branch_taken, branch_target, imem_data,
      output imem_addr, if_id_valid, if_id_pc, if_id_instr, halted
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_data,
      input  imem_addr, if_id_valid, if_id_pc, if_id_instr, halted
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush, kill and hold controls.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W    = DEF_PC_W,
   parameter int unsigned INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  ifid_op_e           op_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic               valid_o,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o
);

   logic               valid_q, valid_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (op_i)
         IFID_LOAD: begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
         end
         IFID_FLUSH: begin
            valid_d = 1'b0;
            instr_d = INSTR_W'(BUBBLE_INSTR);
         end
         IFID_KILL: valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, drives the imem read port and steers the IF/ID register.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned         PC_W        = DEF_PC_W,
   parameter int unsigned         INSTR_W     = DEF_INSTR_W,
   parameter int unsigned         PC_STEP     = 1,
   parameter logic [PC_W-1:0]     RESET_PC    = '0,
   parameter logic [INSTR_W-1:0]  HALT_OPCODE = INSTR_W'(DEF_HALT_OPCODE)
) (
   input  logic    clk,
   input  logic    rst,
   fetch_if.master bus
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            halted_q;
   ifid_op_e        ifid_op;

   // Priority in RUN/HALT: redirect beats stall beats normal fetch
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ifid_op = IFID_HOLD;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN, ST_HALT: begin
            if (bus.branch_taken) begin
               pc_d    = bus.branch_target;
               ifid_op = IFID_FLUSH;
               state_d = ST_RUN;
            end else if (bus.stall) begin
               ifid_op = IFID_HOLD;
            end else if (state_q == ST_RUN) begin
               ifid_op = IFID_LOAD;
               if (bus.imem_data == HALT_OPCODE) begin
                  state_d = ST_HALT;
               end else begin
                  pc_d = pc_q + PC_W'(PC_STEP);
               end
            end else begin
               ifid_op = IFID_KILL;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= (state_d == ST_HALT);
      end
   end

   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .op_i    (ifid_op),
      .pc_i    (pc_q),
      .instr_i (bus.imem_data),
      .valid_o (bus.if_id_valid),
      .pc_o    (bus.if_id_pc),
      .instr_o (bus.if_id_instr)
   );

   assign bus.imem_addr = pc_q;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural combinational instruction memory.
module tb_fetch_controller;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [15:0] mem [256];

   fetch_if bus ();

   fetch_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_data = mem[bus.imem_addr];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [7:0] pc,
                             input logic [15:0] instr, input logic [7:0] addr);
      check_eq({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
      check_eq({tag, ".pc"},    32'(bus.if_id_pc),    32'(pc));
      check_eq({tag, ".instr"}, 32'(bus.if_id_instr), 32'(instr));
      check_eq({tag, ".addr"},  32'(bus.imem_addr),   32'(addr));
   endtask

   task automatic redirect(input logic [7:0] tgt, input logic st);
      bus.branch_taken  = 1'b1;
      bus.branch_target = tgt;
      bus.stall         = st;
      tick();
      bus.branch_taken  = 1'b0;
      bus.branch_target = 'x;
      bus.stall         = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0] = 16'h000F;
      mem[1] = 16'h00F0;
      mem[2] = 16'h0F0F;
      mem[7] = 16'hFFFF;

      rst               = 1'b1;
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 'x;
      #12;
      check_ifid("reset", 1'b0, 8'h00, 16'h0000, 8'h00);
      check_eq("reset.halted", 32'(bus.halted), 32'd0);

      @(negedge clk) rst = 1'b0;
      tick();
      check_ifid("boot", 1'b0, 8'h00, 16'h0000, 8'h00);
      tick(); check_ifid("seq0", 1'b1, 8'h00, 16'h000F, 8'h01);
      tick(); check_ifid("seq1", 1'b1, 8'h01, 16'h00F0, 8'h02);
      tick(); check_ifid("seq2", 1'b1, 8'h02, 16'h0F0F, 8'h03);

      bus.stall = 1'b1;
      tick(); check_ifid("stall1", 1'b1, 8'h02, 16'h0F0F, 8'h03);
      tick(); check_ifid("stall2", 1'b1, 8'h02, 16'h0F0F, 8'h03);
      bus.stall = 1'b0;
      tick(); check_ifid("unstall", 1'b1, 8'h03, 16'h1003, 8'h04);
      tick(); check_ifid("seq4", 1'b1, 8'h04, 16'h1004, 8'h05);

      redirect(8'h40, 1'b0);
      check_ifid("br_flush", 1'b0, 8'h04, 16'h0000, 8'h40);
      tick(); check_ifid("br_tgt", 1'b1, 8'h40, 16'h1040, 8'h41);

      redirect(8'h10, 1'b1);
      check_ifid("brst_flush", 1'b0, 8'h40, 16'h0000, 8'h10);
      tick(); check_ifid("brst_tgt", 1'b1, 8'h10, 16'h1010, 8'h11);

      redirect(8'h07, 1'b0);
      check_eq("pre_halt.halted", 32'(bus.halted), 32'd0);
      tick();
      check_ifid("halt_word", 1'b1, 8'h07, 16'hFFFF, 8'h07);
      check_eq("halt_word.halted", 32'(bus.halted), 32'd1);
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("parked.valid",  32'(bus.if_id_valid), 32'd0);
         check_eq("parked.addr",   32'(bus.imem_addr),   32'h07);
         check_eq("parked.halted", 32'(bus.halted),      32'd1);
      end
      redirect(8'h02, 1'b0);
      check_eq("resume.halted", 32'(bus.halted), 32'd0);
      check_ifid("resume_flush", 1'b0, 8'h07, 16'h0000, 8'h02);
      tick(); check_ifid("resume_tgt", 1'b1, 8'h02, 16'h0F0F, 8'h03);

      redirect(8'hFF, 1'b0);
      check_eq("wrap.addr", 32'(bus.imem_addr), 32'hFF);
      tick(); check_ifid("wrap_ff", 1'b1, 8'hFF, 16'h10FF, 8'h00);
      tick(); check_ifid("wrap_00", 1'b1, 8'h00, 16'h000F, 8'h01);

      redirect(8'h07, 1'b0);
      tick();
      check_eq("prerst.halted", 32'(bus.halted), 32'd1);
      #3 rst = 1'b1;
      #1;
      check_ifid("midrst", 1'b0, 8'h00, 16'h0000, 8'h00);
      check_eq("midrst.halted", 32'(bus.halted), 32'd0);

      @(negedge clk) rst = 1'b0;
      tick(); check_ifid("reboot", 1'b0, 8'h00, 16'h0000, 8'h00);
      tick(); check_ifid("refetch", 1'b1, 8'h00, 16'h000F, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
